// File: rtl/svm_dwell_if.sv
// Bundle between the SVM vector sequencer and the dwell monitor.
// Sequencer side (master) drives SYNC, SECTOR_IN and the one-hot strobes U_0/U_1/U_2/U_7.
// Monitor side (slave) returns the dwell counts of the last closed window (T_*_MEAS),
// its sector (SECTOR_MEAS), the MEAS_VALID update pulse and the SEQ_ERR flag.
interface svm_dwell_if;
  logic        SYNC;
  logic [2:0]  SECTOR_IN;
  logic        U_0;
  logic        U_1;
  logic        U_2;
  logic        U_7;
  logic [14:0] T_0_MEAS;
  logic [14:0] T_1_MEAS;
  logic [14:0] T_2_MEAS;
  logic [14:0] T_7_MEAS;
  logic [2:0]  SECTOR_MEAS;
  logic        MEAS_VALID;
  logic        SEQ_ERR;

  modport master (
    output SYNC, SECTOR_IN, U_0, U_1, U_2, U_7,
    input  T_0_MEAS, T_1_MEAS, T_2_MEAS, T_7_MEAS, SECTOR_MEAS, MEAS_VALID, SEQ_ERR
  );

  modport slave (
    input  SYNC, SECTOR_IN, U_0, U_1, U_2, U_7,
    output T_0_MEAS, T_1_MEAS, T_2_MEAS, T_7_MEAS, SECTOR_MEAS, MEAS_VALID, SEQ_ERR
  );
endinterface

// File: rtl/svm_dwell_monitor.sv
// Space-vector dwell monitor. Per sampling window (index 0..TAST_PERIOD, or cut short by
// SYNC) counts the cycles each active-vector strobe was high, checks that strobes follow
// the symmetric order U_0,U_1,U_2,U_7,U_2,U_1 and reports the result one cycle after the
// window's last cycle with a MEAS_VALID pulse.
// Ports:
//   CLK      - system clock, rising edge
//   RESET_N  - synchronous active-low reset
//   bus      - svm_dwell_if slave: SYNC, SECTOR_IN, U_* in; T_*_MEAS, SECTOR_MEAS,
//              MEAS_VALID, SEQ_ERR out
module svm_dwell_monitor #(
  parameter int unsigned F_CLK       = 100000000,
  parameter int unsigned F_TAST      = 10000,
  parameter int unsigned TAST_PERIOD = F_CLK / F_TAST
) (
  input logic        CLK,
  input logic        RESET_N,
  svm_dwell_if.slave bus
);

  localparam int unsigned IdxW = (TAST_PERIOD > 1) ? $clog2(TAST_PERIOD + 1) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(TAST_PERIOD);
  localparam logic [14:0] AccMax = 15'h7fff;

  // State codes equal the position in the sequence so "forward or stay" is a compare.
  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StS0   = 3'd1;
  localparam logic [2:0] StS1   = 3'd2;
  localparam logic [2:0] StS2   = 3'd3;
  localparam logic [2:0] StS7   = 3'd4;
  localparam logic [2:0] StS2b  = 3'd5;
  localparam logic [2:0] StS1b  = 3'd6;

  logic [IdxW-1:0] idx_q, idx_d;
  logic [2:0]      state_q, state_d;
  logic [14:0]     acc_q [4];
  logic [14:0]     acc_d [4];
  logic [14:0]     acc_inc [4];
  logic [14:0]     meas_q [4];
  logic [14:0]     meas_d [4];
  logic            err_acc_q, err_acc_d;
  logic [2:0]      sec_q, sec_d;
  logic            seen_q, seen_d;
  logic [2:0]      sec_meas_q, sec_meas_d;
  logic            valid_q, valid_d;
  logic            seq_err_q, seq_err_d;

  logic [3:0] strb;
  logic       last;
  logic       overlap;
  logic       onehot;
  logic       ord_err;
  logic [2:0] tgt;

  assign strb    = {bus.U_7, bus.U_2, bus.U_1, bus.U_0};
  assign last    = bus.SYNC || (idx_q == IdxLast);
  assign overlap = (strb & (strb - 4'd1)) != 4'd0;
  assign onehot  = (strb != 4'd0) && !overlap;

  // Target state for a single strobe; an illegal (backward) move holds the state.
  always_comb begin
    tgt     = state_q;
    ord_err = 1'b0;
    if (onehot) begin
      unique case (1'b1)
        strb[0]: begin
          if (state_q <= StS0) tgt = StS0;
          else                 ord_err = 1'b1;
        end
        strb[1]: begin
          if (state_q <= StS1) tgt = StS1;
          else                 tgt = StS1b;
        end
        strb[2]: begin
          if (state_q <= StS2)       tgt = StS2;
          else if (state_q <= StS2b) tgt = StS2b;
          else                       ord_err = 1'b1;
        end
        strb[3]: begin
          if (state_q <= StS7) tgt = StS7;
          else                 ord_err = 1'b1;
        end
        default: tgt = state_q;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      acc_inc[i] = (strb[i] && acc_q[i] != AccMax) ? acc_q[i] + 15'd1 : acc_q[i];
      acc_d[i]   = acc_inc[i];
      meas_d[i]  = meas_q[i];
    end
    idx_d      = idx_q + IdxW'(1);
    state_d    = tgt;
    err_acc_d  = err_acc_q | overlap | ord_err;
    sec_d      = sec_q;
    seen_d     = seen_q;
    sec_meas_d = sec_meas_q;
    valid_d    = 1'b0;
    seq_err_d  = seq_err_q;

    if (!seen_q && strb != 4'd0) begin
      sec_d  = bus.SECTOR_IN;
      seen_d = 1'b1;
    end

    if (last) begin
      for (int i = 0; i < 4; i++) begin
        meas_d[i] = acc_inc[i];
        acc_d[i]  = '0;
      end
      // Unlatched at the last cycle means either a strobe first appears now or the window
      // was empty; both cases take the current sector word.
      sec_meas_d = seen_q ? sec_q : bus.SECTOR_IN;
      seq_err_d  = err_acc_q | overlap | ord_err;
      valid_d    = 1'b1;
      idx_d      = '0;
      state_d    = StIdle;
      err_acc_d  = 1'b0;
      sec_d      = '0;
      seen_d     = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      idx_q      <= '0;
      state_q    <= StIdle;
      err_acc_q  <= 1'b0;
      sec_q      <= '0;
      seen_q     <= 1'b0;
      sec_meas_q <= '0;
      valid_q    <= 1'b0;
      seq_err_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        acc_q[i]  <= '0;
        meas_q[i] <= '0;
      end
    end else begin
      idx_q      <= idx_d;
      state_q    <= state_d;
      err_acc_q  <= err_acc_d;
      sec_q      <= sec_d;
      seen_q     <= seen_d;
      sec_meas_q <= sec_meas_d;
      valid_q    <= valid_d;
      seq_err_q  <= seq_err_d;
      for (int i = 0; i < 4; i++) begin
        acc_q[i]  <= acc_d[i];
        meas_q[i] <= meas_d[i];
      end
    end
  end

  assign bus.T_0_MEAS    = meas_q[0];
  assign bus.T_1_MEAS    = meas_q[1];
  assign bus.T_2_MEAS    = meas_q[2];
  assign bus.T_7_MEAS    = meas_q[3];
  assign bus.SECTOR_MEAS = sec_meas_q;
  assign bus.MEAS_VALID  = valid_q;
  assign bus.SEQ_ERR     = seq_err_q;

endmodule
